// File: rtl/mem_moc_ram.sv
// mem_moc_ram: byte-addressable big-endian RAM with programmable wait states and MOC handshake.
module mem_moc_ram #(
   parameter int DEPTH_BYTES = 512,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W = 9
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        memEnable,
   input  logic        rw,
   input  logic [1:0]  size,
   input  logic        unSign,
   input  logic [31:0] memAdress,
   input  logic [31:0] dataIn,
   output logic [31:0] memData,
   output logic        MOC,
   output logic        busy,
   output logic        error
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state, stateNext;
   logic [3:0] cnt;
   logic rwQ, unSignQ;
   logic [1:0] sizeQ;
   logic [ADDR_W-1:0] addrQ;
   logic [31:0] dataQ;
   logic [7:0] mem [DEPTH_BYTES];
   logic direct, doAccess, aRw, aUn, aErr, wrEn, unusedAddr;
   logic [1:0] aSize;
   logic [ADDR_W-1:0] a0, a1, a2, a3;
   logic [31:0] aData, rdData;
   logic [15:0] half;
   assign unusedAddr = ^memAdress[31:ADDR_W];
   // With no wait states the access happens on the acceptance edge, straight from the inputs.
   assign direct = (WAIT_CYCLES == 0) && state == IDLE && memEnable;
   always_comb begin
      aRw = direct ? rw : rwQ;
      aUn = direct ? unSign : unSignQ;
      aSize = direct ? size : sizeQ;
      aData = direct ? dataIn : dataQ;
      a0 = direct ? memAdress[ADDR_W-1:0] : addrQ;
      a1 = a0 + ADDR_W'(1);
      a2 = a0 + ADDR_W'(2);
      a3 = a0 + ADDR_W'(3);
      aErr = aSize == 2'b11 || (aSize == 2'b01 && a0[0]) || (aSize == 2'b10 && a0[1:0] != 2'b00);
      half = {mem[a0], mem[a1]};
      rdData = aSize == 2'b10 ? {mem[a0], mem[a1], mem[a2], mem[a3]}
             : aSize == 2'b01 ? {{16{~aUn & half[15]}}, half}
             : {{24{~aUn & mem[a0][7]}}, mem[a0]};
      doAccess = direct || (state == WAIT && cnt == 4'(WAIT_CYCLES - 1));
      stateNext = state == IDLE ? (memEnable ? (WAIT_CYCLES == 0 ? DONE : WAIT) : IDLE)
                : state == WAIT ? (doAccess ? DONE : WAIT)
                : (memEnable ? DONE : IDLE);
      wrEn = doAccess && !reset && !aRw && !aErr;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= 4'd0;
         memData <= 32'd0;
         MOC <= 1'b0;
         busy <= 1'b0;
         error <= 1'b0;
      end else begin
         state <= stateNext;
         busy <= stateNext != IDLE;
         MOC <= stateNext == DONE;
         cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
         if (state == IDLE && memEnable) begin
            rwQ <= rw;
            sizeQ <= size;
            unSignQ <= unSign;
            addrQ <= memAdress[ADDR_W-1:0];
            dataQ <= dataIn;
         end
         if (doAccess) begin
            error <= aErr;
            if (aErr) memData <= 32'd0;
            else if (aRw) memData <= rdData;
         end else if (stateNext == IDLE) error <= 1'b0;
      end
   end
   // Array has no reset; bytes outside the access width are untouched.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         if (aSize == 2'b00) mem[a0] <= aData[7:0];
         else if (aSize == 2'b01) begin
            mem[a0] <= aData[15:8];
            mem[a1] <= aData[7:0];
         end else begin
            mem[a0] <= aData[31:24];
            mem[a1] <= aData[23:16];
            mem[a2] <= aData[15:8];
            mem[a3] <= aData[7:0];
         end
      end
   end
endmodule
